// File: rtl/ram_bus_arbiter_pkg.sv
// Shared definitions for the two-master RAM front end: RAM geometry, window width, FSM states.
package ram_bus_arbiter_pkg;

  localparam int MEMORYSIZE = 8 * 1024;
  localparam int BYTE_AW    = $clog2(MEMORYSIZE);
  localparam int RAM_AW     = BYTE_AW - 2;
  localparam int WIN_W      = 32 - BYTE_AW;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

  function automatic logic win_hit(input logic [31:0] addr, input logic [31:0] base);
    return addr[31 -: WIN_W] == base[31 -: WIN_W];
  endfunction

endpackage

// File: rtl/ram_bus_arbiter_rr_arb2.sv
// Combinational 2-way arbiter; the caller keeps the last-grant history.
module ram_bus_arbiter_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       mode_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // Tie: fixed priority favours master 0; round-robin favours whoever did not win last.
      2'b11:   gnt_o = (mode_i || last_i) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Two-master arbiter in front of a single-port registered-read RAM; one transfer every two cycles.
// Handshake: a master holds valid/addr/wdata/wstrb until its one-cycle ready pulse; rdata/err are meaningful only with ready.
module ram_bus_arbiter
  import ram_bus_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit          ARB_MODE  = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_valid,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic [RAM_AW-1:0] ram_address,
  output logic [3:0]        ram_byteena,
  output logic [31:0]       ram_data,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [31:0]       ram_q,
  output state_e            dbg_state_o
);

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic        rd_q, rd_d;
  logic [1:0]  gnt;
  logic        sel;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        hit;
  logic [31:0] resp_data;
  logic        unused_addr_lsb;

  ram_bus_arbiter_rr_arb2 u_arb (
    .req_i  ({m1_valid, m0_valid}),
    .last_i (last_q),
    .mode_i (ARB_MODE),
    .gnt_o  (gnt)
  );

  assign sel       = gnt[1];
  assign sel_addr  = sel ? m1_addr : m0_addr;
  assign sel_wdata = sel ? m1_wdata : m0_wdata;
  assign sel_wstrb = sel ? m1_wstrb : m0_wstrb;
  assign hit       = win_hit(sel_addr, BASE_ADDR);
  assign unused_addr_lsb = ^sel_addr[1:0];
  assign dbg_state_o     = state_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    err_d       = err_q;
    rd_d        = rd_q;
    ram_address = '0;
    ram_byteena = '0;
    ram_data    = '0;
    ram_rden    = 1'b0;
    ram_wren    = 1'b0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_err      = 1'b0;
    m1_err      = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;
    resp_data   = rd_q ? ram_q : 32'h0;
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          grant_d     = sel;
          last_d      = sel;
          err_d       = !hit;
          rd_d        = hit && (sel_wstrb == 4'b0000);
          state_d     = ST_ACK;
          ram_address = sel_addr[RAM_AW+1:2];
          ram_byteena = sel_wstrb;
          ram_data    = sel_wdata;
          ram_wren    = hit && (sel_wstrb != 4'b0000);
          ram_rden    = hit && (sel_wstrb == 4'b0000);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        if (grant_q) begin
          m1_ready = 1'b1;
          m1_err   = err_q;
          m1_rdata = resp_data;
        end else begin
          m0_ready = 1'b1;
          m0_err   = err_q;
          m0_rdata = resp_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset suppresses every strobe and completion immediately, even mid-ACK.
    if (reset) begin
      ram_rden = 1'b0;
      ram_wren = 1'b0;
      m0_ready = 1'b0;
      m1_ready = 1'b0;
      m0_err   = 1'b0;
      m1_err   = 1'b0;
      m0_rdata = '0;
      m1_rdata = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: two instances (round-robin at base 0, fixed priority at base 0x2000), each with a RAM model.
module tb_ram_bus_arbiter;
  import ram_bus_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT signals, indexed [dut][master] ----------------
  logic        valid [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic [3:0]  wstrb [2][2];
  logic        ready [2][2];
  logic [31:0] rdata [2][2];
  logic        err   [2][2];
  logic [10:0] ram_addr [2];
  logic [3:0]  byteena  [2];
  logic [31:0] wdat     [2];
  logic        rden     [2];
  logic        wren     [2];
  logic [31:0] ram_q    [2];
  state_e      dbg      [2];
  logic [31:0] mem [2][2048];

  ram_bus_arbiter #(.BASE_ADDR(32'h0000_0000), .ARB_MODE(1'b0)) u_dut0 (
    .clock(clock), .reset(reset),
    .m0_valid(valid[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]), .m0_wstrb(wstrb[0][0]),
    .m0_ready(ready[0][0]), .m0_rdata(rdata[0][0]), .m0_err(err[0][0]),
    .m1_valid(valid[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]), .m1_wstrb(wstrb[0][1]),
    .m1_ready(ready[0][1]), .m1_rdata(rdata[0][1]), .m1_err(err[0][1]),
    .ram_address(ram_addr[0]), .ram_byteena(byteena[0]), .ram_data(wdat[0]),
    .ram_rden(rden[0]), .ram_wren(wren[0]), .ram_q(ram_q[0]), .dbg_state_o(dbg[0])
  );

  ram_bus_arbiter #(.BASE_ADDR(32'h0000_2000), .ARB_MODE(1'b1)) u_dut1 (
    .clock(clock), .reset(reset),
    .m0_valid(valid[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]), .m0_wstrb(wstrb[1][0]),
    .m0_ready(ready[1][0]), .m0_rdata(rdata[1][0]), .m0_err(err[1][0]),
    .m1_valid(valid[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]), .m1_wstrb(wstrb[1][1]),
    .m1_ready(ready[1][1]), .m1_rdata(rdata[1][1]), .m1_err(err[1][1]),
    .ram_address(ram_addr[1]), .ram_byteena(byteena[1]), .ram_data(wdat[1]),
    .ram_rden(rden[1]), .ram_wren(wren[1]), .ram_q(ram_q[1]), .dbg_state_o(dbg[1])
  );

  // Single-port RAM model: byte-enabled write, registered read every clock.
  always @(posedge clock) begin
    for (int g = 0; g < 2; g++) begin
      for (int b = 0; b < 4; b++)
        if (wren[g] && byteena[g][b]) mem[g][ram_addr[g]][8*b +: 8] <= wdat[g][8*b +: 8];
      ram_q[g] <= mem[g][ram_addr[g]];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp0_q[$];   // {master, err, rdata}
  logic [33:0] exp1_q[$];
  logic [12:0] ram0_q[$];   // {wren, rden, word address}
  logic [12:0] ram1_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic expect_rsp(input int d, input logic m, input logic e, input logic [31:0] rd);
    if (d == 0) exp0_q.push_back({m, e, rd});
    else        exp1_q.push_back({m, e, rd});
  endtask

  task automatic expect_ram(input int d, input logic wr, input logic [10:0] a);
    if (d == 0) ram0_q.push_back({wr, !wr, a});
    else        ram1_q.push_back({wr, !wr, a});
  endtask

  task automatic mon(input int d);
    logic [33:0] e;
    logic [12:0] re;
    logic        m;
    if (reset) begin
      chk($sformatf("reset_quiet%0d", d),
          {60'h0, ready[d][0], ready[d][1], rden[d], wren[d]}, 64'h0);
      return;
    end
    if (ready[d][0] || ready[d][1]) begin
      m = ready[d][1];
      chk($sformatf("one_ready%0d", d), {63'h0, ready[d][0] && ready[d][1]}, 64'h0);
      chk($sformatf("other_rdata%0d", d), {32'h0, rdata[d][!m]}, 64'h0);
      if ((d == 0 ? exp0_q.size() : exp1_q.size()) == 0) flag($sformatf("unexpected_ready%0d", d));
      else begin
        e = (d == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
        chk($sformatf("resp%0d", d), {30'h0, m, err[d][m], rdata[d][m]}, {30'h0, e});
      end
    end
    if (rden[d] || wren[d]) begin
      if ((d == 0 ? ram0_q.size() : ram1_q.size()) == 0) flag($sformatf("unexpected_strobe%0d", d));
      else begin
        re = (d == 0) ? ram0_q.pop_front() : ram1_q.pop_front();
        chk($sformatf("ram_port%0d", d), {51'h0, wren[d], rden[d], ram_addr[d]}, {51'h0, re});
      end
    end
  endtask

  always @(negedge clock) begin
    mon(0);
    mon(1);
  end

  // ---------------- drivers ----------------
  task automatic do_req(input int d, input int m, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input int exp_lat);
    bit seen = 1'b0;
    int lat = 0;
    @(posedge clock); #1;
    valid[d][m] = 1'b1; addr[d][m] = a; wdata[d][m] = wd; wstrb[d][m] = ws;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clock); #1;
      if (ready[d][m]) begin seen = 1'b1; lat = i; end
    end
    if (!seen) flag($sformatf("timeout d%0d m%0d", d, m));
    else if (exp_lat != 0) chk($sformatf("latency d%0d m%0d", d, m), 64'(lat), 64'(exp_lat));
    valid[d][m] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1; reset = 1'b1;
    repeat (2) @(posedge clock);
    #1; reset = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) begin
        valid[d][m] = 1'b0; addr[d][m] = '0; wdata[d][m] = '0; wstrb[d][m] = '0;
      end
    repeat (3) @(posedge clock);
    #1; reset = 1'b0;
    chk("reset_state0", 64'(dbg[0]), 64'(ST_IDLE));
    chk("reset_state1", 64'(dbg[1]), 64'(ST_IDLE));

    // Full-word write then read back; completion on the second cycle.
    expect_ram(0, 1'b1, 11'd4); expect_rsp(0, 1'b0, 1'b0, 32'h0);
    do_req(0, 0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1);
    expect_ram(0, 1'b0, 11'd4); expect_rsp(0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    do_req(0, 0, 32'h10, 32'h0, 4'h0, 1);

    // Byte-lane write over an existing word.
    expect_ram(0, 1'b1, 11'd8); expect_rsp(0, 1'b0, 1'b0, 32'h0);
    do_req(0, 0, 32'h20, 32'h1122_3344, 4'hF, 1);
    expect_ram(0, 1'b1, 11'd8); expect_rsp(0, 1'b0, 1'b0, 32'h0);
    do_req(0, 0, 32'h20, 32'h00AB_0000, 4'b0100, 1);
    expect_ram(0, 1'b0, 11'd8); expect_rsp(0, 1'b0, 1'b0, 32'h11AB_3344);
    do_req(0, 0, 32'h20, 32'h0, 4'h0, 1);

    // Window relocated to 0x2000: word index and low-bit wrap.
    expect_ram(1, 1'b1, 11'd0); expect_rsp(1, 1'b0, 1'b0, 32'h0);
    do_req(1, 0, 32'h2000, 32'hA5A5_0001, 4'hF, 1);
    expect_ram(1, 1'b1, 11'd1); expect_rsp(1, 1'b0, 1'b0, 32'h0);
    do_req(1, 0, 32'h2004, 32'hCAFE_F00D, 4'hF, 1);
    expect_ram(1, 1'b0, 11'd0); expect_rsp(1, 1'b0, 1'b0, 32'hA5A5_0001);
    do_req(1, 0, 32'h2003, 32'h0, 4'h0, 1);

    // Out-of-window access from master 1: error, zero data, no RAM strobe.
    expect_rsp(0, 1'b1, 1'b1, 32'h0);
    do_req(0, 1, 32'h0000_4000, 32'h0, 4'h0, 1);

    // Round-robin under contention, starting from reset history.
    do_reset();
    expect_ram(0, 1'b0, 11'd4); expect_rsp(0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    expect_ram(0, 1'b0, 11'd8); expect_rsp(0, 1'b1, 1'b0, 32'h11AB_3344);
    expect_ram(0, 1'b0, 11'd4); expect_rsp(0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    expect_ram(0, 1'b0, 11'd8); expect_rsp(0, 1'b1, 1'b0, 32'h11AB_3344);
    expect_ram(0, 1'b0, 11'd4); expect_rsp(0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    fork
      for (int i = 0; i < 3; i++) do_req(0, 0, 32'h10, 32'h0, 4'h0, 0);
      for (int i = 0; i < 2; i++) do_req(0, 1, 32'h20, 32'h0, 4'h0, 0);
    join

    // Fixed priority: master 1 waits while master 0 keeps requesting.
    for (int i = 0; i < 4; i++) begin
      expect_ram(1, 1'b0, 11'd1); expect_rsp(1, 1'b0, 1'b0, 32'hCAFE_F00D);
    end
    expect_ram(1, 1'b0, 11'd0); expect_rsp(1, 1'b1, 1'b0, 32'hA5A5_0001);
    fork
      for (int i = 0; i < 4; i++) do_req(1, 0, 32'h2004, 32'h0, 4'h0, 0);
      do_req(1, 1, 32'h2000, 32'h0, 4'h0, 0);
    join

    // Reset lands in the ACK cycle of a write: no ready, data still committed.
    expect_ram(0, 1'b1, 11'd12);
    @(posedge clock); #1;
    valid[0][0] = 1'b1; addr[0][0] = 32'h30; wdata[0][0] = 32'h1234_5678; wstrb[0][0] = 4'hF;
    @(posedge clock); #1;
    chk("ack_state", 64'(dbg[0]), 64'(ST_ACK));
    reset = 1'b1;
    valid[0][0] = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("post_reset_state", 64'(dbg[0]), 64'(ST_IDLE));
    expect_ram(0, 1'b0, 11'd12); expect_rsp(0, 1'b0, 1'b0, 32'h1234_5678);
    do_req(0, 0, 32'h30, 32'h0, 4'h0, 1);

    for (int i = 0; i < 20 && (exp0_q.size() + exp1_q.size() + ram0_q.size() + ram1_q.size()) != 0; i++)
      @(posedge clock);
    repeat (2) @(posedge clock);
    chk("exp0_drained", 64'(exp0_q.size()), 64'h0);
    chk("exp1_drained", 64'(exp1_q.size()), 64'h0);
    chk("ram0_drained", 64'(ram0_q.size()), 64'h0);
    chk("ram1_drained", 64'(ram1_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
